// File: rtl/comma_align_deser.sv
// Serial 8b10b comma aligner and deserializer: hunts for K28.5 in the bit stream,
// confirms the word phase on a second comma and emits aligned 10-bit code groups.
module comma_align_deser #(
    parameter logic [9:0] COMMA_N     = 10'h17C,
    parameter logic [9:0] COMMA_P     = 10'h283,
    parameter int         LOSS_THRESH = 3
) (
    input  logic       bitclk,
    input  logic       reset,
    input  logic       sigIn,
    output logic [9:0] word_out,
    output logic       word_valid,
    output logic       is_comma,
    output logic       locked,
    output logic       realign,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // miscnt is a 2-bit saturating counter, so the usable threshold is 1..3.
    localparam int         LIM_I    = (LOSS_THRESH < 1) ? 1 : ((LOSS_THRESH > 3) ? 3 : LOSS_THRESH);
    localparam logic [1:0] LOSS_LIM = LIM_I[1:0];

    state_t     state;
    state_t     state_nx;
    logic [9:0] sr;
    logic [3:0] bitcnt;
    logic [3:0] bitcnt_nx;
    logic [1:0] miscnt;
    logic [1:0] miscnt_nx;
    logic [1:0] mis_inc;
    logic       comma_hit;
    logic       at_boundary;
    logic       emit;
    logic       emit_comma;
    logic       realign_nx;

    assign comma_hit   = (sr == COMMA_N) || (sr == COMMA_P);
    assign at_boundary = (bitcnt == 4'd0);
    assign mis_inc     = (miscnt == 2'd3) ? 2'd3 : miscnt + 2'd1;

    always_comb begin
        state_nx   = state;
        miscnt_nx  = miscnt;
        bitcnt_nx  = (bitcnt == 4'd9) ? 4'd0 : bitcnt + 4'd1;
        emit       = 1'b0;
        emit_comma = 1'b0;
        realign_nx = 1'b0;
        case (state)
            ST_HUNT: begin
                if (comma_hit) begin
                    bitcnt_nx  = 4'd1;
                    emit       = 1'b1;
                    emit_comma = 1'b1;
                    realign_nx = 1'b1;
                    state_nx   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (at_boundary) begin
                    emit       = 1'b1;
                    emit_comma = comma_hit;
                    if (comma_hit) begin
                        state_nx = ST_LOCKED;
                    end
                end else if (comma_hit) begin
                    // Not yet trusted: follow the newest comma phase.
                    bitcnt_nx  = 4'd1;
                    emit       = 1'b1;
                    emit_comma = 1'b1;
                    realign_nx = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (at_boundary) begin
                    emit       = 1'b1;
                    emit_comma = comma_hit;
                    if (comma_hit) begin
                        miscnt_nx = 2'd0;
                    end
                end else if (comma_hit) begin
                    // Stray commas are tolerated until LOSS_LIM in a row.
                    if (mis_inc >= LOSS_LIM) begin
                        state_nx  = ST_HUNT;
                        miscnt_nx = 2'd0;
                    end else begin
                        miscnt_nx = mis_inc;
                    end
                end
            end
            default: begin
                state_nx  = ST_HUNT;
                miscnt_nx = 2'd0;
            end
        endcase
    end

    // word_valid is a single-cycle strobe with no back-pressure: word_out,
    // is_comma and realign are meaningful only in the cycle it is high.
    always_ff @(posedge bitclk) begin
        if (reset) begin
            sr         <= 10'd0;
            bitcnt     <= 4'd0;
            miscnt     <= 2'd0;
            state      <= ST_HUNT;
            word_out   <= 10'd0;
            word_valid <= 1'b0;
            is_comma   <= 1'b0;
            realign    <= 1'b0;
        end else begin
            sr         <= {sigIn, sr[9:1]};
            bitcnt     <= bitcnt_nx;
            miscnt     <= miscnt_nx;
            state      <= state_nx;
            word_valid <= emit;
            is_comma   <= emit_comma;
            realign    <= realign_nx;
            if (emit) begin
                word_out <= sr;
            end
        end
    end

    assign locked    = (state == ST_LOCKED);
    assign state_dbg = state;

endmodule
